// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: EX register, ALU, data-SRAM request,
// HI/LO registers, combinational multiplier and a 32-step restoring divider.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_ID_WD  = 38,
    parameter int DIV_CYCLES   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [5:0]              stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_ID_WD-1:0]  ex_to_id_bus,
    output logic                    is_load,
    output logic                    stallreq_from_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_t;

    logic [ID_TO_EX_WD-1:0] ex_reg;

    // A stopped EX with a running MEM must emit a bubble, otherwise the
    // instruction would be duplicated downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_reg <= '0;
        end else if (stall[2] && !stall[3]) begin
            ex_reg <= '0;
        end else if (!stall[2]) begin
            ex_reg <= id_to_ex_bus;
        end
    end

    logic [31:0] pc;
    logic [31:0] inst;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic        sel_rf_res;
    logic [31:0] rdata1;
    logic [31:0] rdata2;

    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
            rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = ex_reg;

    logic unused_bits;
    assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

    logic is_special;
    logic is_mult, is_multu, is_div, is_divu;
    logic is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic div_any;

    assign is_special = (inst[31:26] == 6'b000000);
    assign is_mult    = is_special && (inst[5:0] == 6'b011000);
    assign is_multu   = is_special && (inst[5:0] == 6'b011001);
    assign is_div     = is_special && (inst[5:0] == 6'b011010);
    assign is_divu    = is_special && (inst[5:0] == 6'b011011);
    assign is_mfhi    = is_special && (inst[5:0] == 6'b010000);
    assign is_mthi    = is_special && (inst[5:0] == 6'b010001);
    assign is_mflo    = is_special && (inst[5:0] == 6'b010010);
    assign is_mtlo    = is_special && (inst[5:0] == 6'b010011);
    assign div_any    = is_div || is_divu;

    logic [31:0] src1, src2;
    logic [31:0] imm_sext, imm_zext;

    assign imm_sext = {{16{inst[15]}}, inst[15:0]};
    assign imm_zext = {16'h0000, inst[15:0]};

    assign src1 = ({32{sel_src1[0]}} & rdata1)
                | ({32{sel_src1[1]}} & pc)
                | ({32{sel_src1[2]}} & {27'd0, inst[10:6]});

    assign src2 = ({32{sel_src2[0]}} & rdata2)
                | ({32{sel_src2[1]}} & imm_sext)
                | ({32{sel_src2[2]}} & 32'd8)
                | ({32{sel_src2[3]}} & imm_zext);

    logic [31:0] sum, diff, slt_res, sltu_res, sll_res, srl_res, sra_res, lui_res;
    logic [31:0] alu_res;

    assign sum      = src1 + src2;
    assign diff     = src1 - src2;
    assign slt_res  = {31'd0, ($signed(src1) < $signed(src2))};
    assign sltu_res = {31'd0, (src1 < src2)};
    assign sll_res  = src2 << src1[4:0];
    assign srl_res  = src2 >> src1[4:0];
    assign sra_res  = $signed(src2) >>> src1[4:0];
    assign lui_res  = {src2[15:0], 16'h0000};

    // alu_op is one-hot, so an AND-OR mux yields 0 when no operation is selected.
    assign alu_res = ({32{alu_op[11]}} & sum)
                   | ({32{alu_op[10]}} & diff)
                   | ({32{alu_op[9]}}  & slt_res)
                   | ({32{alu_op[8]}}  & sltu_res)
                   | ({32{alu_op[7]}}  & (src1 & src2))
                   | ({32{alu_op[6]}}  & ~(src1 | src2))
                   | ({32{alu_op[5]}}  & (src1 | src2))
                   | ({32{alu_op[4]}}  & (src1 ^ src2))
                   | ({32{alu_op[3]}}  & sll_res)
                   | ({32{alu_op[2]}}  & srl_res)
                   | ({32{alu_op[1]}}  & sra_res)
                   | ({32{alu_op[0]}}  & lui_res);

    logic [63:0] prod_s, prod_u;

    assign prod_s = $signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2});
    assign prod_u = {32'd0, rdata1} * {32'd0, rdata2};

    div_state_t       div_state;
    logic [CNT_W-1:0] div_cnt;
    logic [31:0]      div_rem, div_quo, div_dsor;
    logic             div_neg_q, div_neg_r, div_by_zero;
    logic [32:0]      div_shift;
    logic             div_ge;
    logic [31:0]      div_sub;

    assign div_shift = {div_rem, div_quo[31]};
    assign div_ge    = (div_shift >= {1'b0, div_dsor});
    assign div_sub   = div_shift[31:0] - div_dsor;

    // Operands are taken as magnitudes; the signs are re-applied once the
    // unsigned quotient/remainder are complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_state   <= DIV_IDLE;
            div_cnt     <= '0;
            div_rem     <= '0;
            div_quo     <= '0;
            div_dsor    <= '0;
            div_neg_q   <= 1'b0;
            div_neg_r   <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            case (div_state)
                DIV_IDLE: begin
                    if (div_any) begin
                        div_state   <= DIV_BUSY;
                        div_cnt     <= '0;
                        div_rem     <= '0;
                        div_quo     <= (is_div && rdata1[31]) ? -rdata1 : rdata1;
                        div_dsor    <= (is_div && rdata2[31]) ? -rdata2 : rdata2;
                        div_neg_q   <= is_div && (rdata1[31] ^ rdata2[31]);
                        div_neg_r   <= is_div && rdata1[31];
                        div_by_zero <= (rdata2 == 32'd0);
                    end
                end
                DIV_BUSY: begin
                    div_rem <= div_ge ? div_sub : div_shift[31:0];
                    div_quo <= {div_quo[30:0], div_ge};
                    div_cnt <= div_cnt + 1'b1;
                    if (div_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                        div_state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    div_state <= DIV_IDLE;
                end
                default: begin
                    div_state <= DIV_IDLE;
                end
            endcase
        end
    end

    logic [31:0] div_q_res, div_r_res;

    assign div_q_res = div_by_zero ? 32'hFFFF_FFFF : (div_neg_q ? -div_quo : div_quo);
    assign div_r_res = div_neg_r ? -div_rem : div_rem;

    assign stallreq_from_ex = ((div_state == DIV_IDLE) && div_any) || (div_state == DIV_BUSY);

    logic [31:0] hi, lo;

    // Writes are tied to the cycle the instruction leaves EX so each one commits once.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (div_state == DIV_DONE) begin
            hi <= div_r_res;
            lo <= div_q_res;
        end else if (!stall[3]) begin
            if (is_mthi) begin
                hi <= rdata1;
            end
            if (is_mtlo) begin
                lo <= rdata1;
            end
            if (is_mult) begin
                {hi, lo} <= prod_s;
            end
            if (is_multu) begin
                {hi, lo} <= prod_u;
            end
        end
    end

    logic [31:0] ex_result;
    logic        rf_we_eff;
    logic [4:0]  rf_waddr_eff;

    assign ex_result    = is_mfhi ? hi : (is_mflo ? lo : alu_res);
    assign rf_we_eff    = rf_we || is_mfhi || is_mflo;
    assign rf_waddr_eff = (is_mfhi || is_mflo) ? inst[15:11] : rf_waddr;

    assign ex_to_mem_bus = {pc, ram_en, ram_wen, sel_rf_res, rf_we_eff, rf_waddr_eff, ex_result};
    assign ex_to_id_bus  = {rf_we_eff, rf_waddr_eff, ex_result};

    assign is_load         = ram_en && (ram_wen == 4'b0000);
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = sum;
    assign data_sram_wdata = rdata2;

endmodule

// File: tb/tb_ex_stage.sv
// Randomized self-checking bench for ex_stage; a small controller model turns
// stallreq_from_ex into stall=6'b001111 as the real pipeline controller would.
module tb_ex_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic [5:0]   stall;
    logic [5:0]   manualStall;
    logic [158:0] id_to_ex_bus;
    logic [75:0]  ex_to_mem_bus;
    logic [37:0]  ex_to_id_bus;
    logic         is_load;
    logic         stallreq_from_ex;
    logic         data_sram_en;
    logic [3:0]   data_sram_wen;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int checks   = 0;
    int failures = 0;
    logic [31:0] hiModel, loModel;

    ex_stage dut (
        .clk              (clk),
        .rst              (rst),
        .stall            (stall),
        .id_to_ex_bus     (id_to_ex_bus),
        .ex_to_mem_bus    (ex_to_mem_bus),
        .ex_to_id_bus     (ex_to_id_bus),
        .is_load          (is_load),
        .stallreq_from_ex (stallreq_from_ex),
        .data_sram_en     (data_sram_en),
        .data_sram_wen    (data_sram_wen),
        .data_sram_addr   (data_sram_addr),
        .data_sram_wdata  (data_sram_wdata)
    );

    assign stall = manualStall | (stallreq_from_ex ? 6'b001111 : 6'b000000);

    always #5 clk = ~clk;

    localparam logic [11:0] OP_ADD  = 12'b1000_0000_0000;
    localparam logic [11:0] OP_SLT  = 12'b0010_0000_0000;
    localparam logic [11:0] OP_SLTU = 12'b0001_0000_0000;
    localparam logic [11:0] OP_SRA  = 12'b0000_0000_0010;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [158:0] mk(input logic [31:0] pc, input logic [31:0] inst,
                                        input logic [11:0] aop, input logic [2:0] s1,
                                        input logic [3:0] s2, input logic ren,
                                        input logic [3:0] wen, input logic we,
                                        input logic [4:0] wa, input logic srr,
                                        input logic [31:0] r1, input logic [31:0] r2);
        return {pc, inst, aop, s1, s2, ren, wen, we, wa, srr, r1, r2};
    endfunction

    function automatic logic [158:0] specialBus(input logic [5:0] funct, input logic [31:0] r1, input logic [31:0] r2);
        return mk(32'h0, {6'd0, 5'd1, 5'd2, 5'd8, 5'd0, funct}, 12'd0, 3'b001, 4'b0001,
                  1'b0, 4'h0, 1'b0, 5'd0, 1'b0, r1, r2);
    endfunction

    function automatic logic [31:0] refAlu(input int code, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(a % 32);
        case (code)
            0:  return a + b;
            1:  return a - b;
            2:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << sh;
            9:  return b >> sh;
            10: return int'(b) >>> sh;
            default: return b * 32'd65536;
        endcase
    endfunction

    function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r);
        longint la, lb, lq, lr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            if (sgn) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            lq = la / lb;
            lr = la % lb;
            q = lq[31:0];
            r = lr[31:0];
        end
    endfunction

    task automatic applyStimulus(input logic [158:0] bus);
        @(negedge clk);
        id_to_ex_bus = bus;
        manualStall  = 6'b000000;
        @(posedge clk);
        #1;
    endtask

    task automatic checkHiLo(input string tag);
        applyStimulus(specialBus(6'b010000, 32'h0, 32'h0));
        checkOutput({tag, "_mfhi"}, ex_result_of(ex_to_id_bus), hiModel);
        checkOutput({tag, "_mfhi_fwd"}, ex_to_id_bus[37:32], {1'b1, 5'd8});
        applyStimulus(specialBus(6'b010010, 32'h0, 32'h0));
        checkOutput({tag, "_mflo"}, ex_result_of(ex_to_id_bus), loModel);
    endtask

    function automatic logic [31:0] ex_result_of(input logic [37:0] idBus);
        return idBus[31:0];
    endfunction

    task automatic doMult(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        longint p;
        applyStimulus(specialBus(sgn ? 6'b011000 : 6'b011001, a, b));
        if (sgn) p = longint'($signed(a)) * longint'($signed(b));
        else     p = longint'({32'd0, a}) * longint'({32'd0, b});
        hiModel = p[63:32];
        loModel = p[31:0];
    endtask

    task automatic doDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        int cnt;
        logic [31:0] q, r;
        applyStimulus(specialBus(sgn ? 6'b011010 : 6'b011011, a, b));
        cnt = 0;
        while (stallreq_from_ex && cnt < 100) begin
            cnt++;
            @(posedge clk);
            #1;
        end
        checkOutput("div_stall_cycles", cnt, 33);
        refDiv(sgn, a, b, q, r);
        hiModel = r;
        loModel = q;
    endtask

    initial begin
        logic [158:0] bus;
        logic [31:0]  pc, inst, r1, r2, a, b, res, addrExp;
        logic [3:0]   wen;
        logic [4:0]   wa;
        logic         ren, we, srr;
        int           code, s1c, s2c;

        rst          = 1'b1;
        manualStall  = 6'b000000;
        id_to_ex_bus = '0;
        hiModel      = 32'h0;
        loModel      = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_mem_bus", ex_to_mem_bus, 76'd0);
        checkOutput("reset_id_bus", ex_to_id_bus, 38'd0);
        checkOutput("reset_flags", {is_load, stallreq_from_ex, data_sram_en, data_sram_wen}, 7'd0);
        checkOutput("reset_sram", {data_sram_addr, data_sram_wdata}, 64'd0);
        checkHiLo("reset");

        // Abort a running divide with reset; HI/LO are still zero here.
        applyStimulus(specialBus(6'b011010, 32'd100, 32'd3));
        repeat (5) @(posedge clk);
        #1;
        checkOutput("div_busy_stallreq", stallreq_from_ex, 1'b1);
        @(negedge clk);
        id_to_ex_bus = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset_abort_stallreq", stallreq_from_ex, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        checkHiLo("after_abort");

        applyStimulus(mk(32'h400, {6'b001001, 5'd3, 5'd5, 16'h0001}, OP_ADD, 3'b001, 4'b0010,
                         1'b0, 4'h0, 1'b1, 5'd5, 1'b0, 32'h7FFF_FFFF, 32'h0));
        checkOutput("addiu_result", ex_to_mem_bus[31:0], 32'h8000_0000);
        checkOutput("addiu_id_bus", ex_to_id_bus, {1'b1, 5'd5, 32'h8000_0000});

        applyStimulus(mk(32'h404, {6'd0, 5'd0, 5'd2, 5'd3, 5'd4, 6'b000011}, OP_SRA, 3'b100, 4'b0001,
                         1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'hF000_0000));
        checkOutput("sra", ex_to_mem_bus[31:0], 32'hFF00_0000);
        applyStimulus(mk(32'h408, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101011}, OP_SLTU, 3'b001, 4'b0001,
                         1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd1, 32'hFFFF_FFFF));
        checkOutput("sltu", ex_to_mem_bus[31:0], 32'd1);
        applyStimulus(mk(32'h40C, {6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010}, OP_SLT, 3'b001, 4'b0001,
                         1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'd1, 32'hFFFF_FFFF));
        checkOutput("slt", ex_to_mem_bus[31:0], 32'd0);

        doMult(1'b1, 32'hFFFF_FFFF, 32'd2);
        checkOutput("mult_model_hi", hiModel, 32'hFFFF_FFFF);
        checkHiLo("mult");
        doMult(1'b0, 32'hFFFF_FFFF, 32'd2);
        checkOutput("multu_model_hi", hiModel, 32'd1);
        checkHiLo("multu");

        doDiv(1'b1, 32'hFFFF_FFF9, 32'd2);
        checkOutput("div_model_lo", loModel, 32'hFFFF_FFFD);
        checkHiLo("div_neg7_2");
        doDiv(1'b0, 32'd7, 32'd0);
        checkHiLo("divu_by_zero");
        doDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        checkHiLo("div_min_neg1");
        doDiv(1'b1, 32'hFFFF_FFF9, 32'd0);
        checkHiLo("div_neg_by_zero");

        applyStimulus(specialBus(6'b010001, 32'hA5A5_1234, 32'h0));
        hiModel = 32'hA5A5_1234;
        applyStimulus(specialBus(6'b010011, 32'h0BAD_F00D, 32'h0));
        loModel = 32'h0BAD_F00D;
        checkHiLo("mthi_mtlo");

        applyStimulus(mk(32'h500, {6'b100011, 5'd1, 5'd2, 16'hFFFC}, OP_ADD, 3'b001, 4'b0010,
                         1'b1, 4'h0, 1'b1, 5'd2, 1'b1, 32'h100, 32'h1234_5678));
        checkOutput("lw_addr", data_sram_addr, 32'hFC);
        checkOutput("lw_en_wen_load", {data_sram_en, data_sram_wen, is_load}, {1'b1, 4'h0, 1'b1});
        @(negedge clk);
        manualStall  = 6'b001100;
        id_to_ex_bus = specialBus(6'b010001, 32'h1, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("hold_is_load", {is_load, data_sram_addr}, {1'b1, 32'hFC});
        @(negedge clk);
        manualStall = 6'b000100;
        @(posedge clk);
        #1;
        checkOutput("bubble_is_load", is_load, 1'b0);
        checkOutput("bubble_mem_bus", {ex_to_mem_bus, data_sram_en}, 77'd0);

        applyStimulus(mk(32'h504, {6'b101011, 5'd1, 5'd2, 16'h0008}, OP_ADD, 3'b001, 4'b0010,
                         1'b1, 4'hF, 1'b0, 5'd0, 1'b0, 32'h200, 32'hDEAD_BEEF));
        checkOutput("sw_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                    {1'b1, 4'hF, 32'h208, 32'hDEAD_BEEF});
        checkOutput("sw_is_load", is_load, 1'b0);
        checkHiLo("after_bubble");

        for (int i = 0; i < 30; i++) begin
            code = $urandom_range(0, 11);
            s1c  = $urandom_range(0, 2);
            s2c  = $urandom_range(0, 3);
            r1   = $urandom;
            r2   = $urandom;
            pc   = $urandom;
            inst = $urandom;
            if (inst[31:26] == 6'd0) inst[26] = 1'b1;
            ren  = 1'($urandom_range(0, 1));
            wen  = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            we   = 1'($urandom_range(0, 1));
            wa   = 5'($urandom);
            srr  = 1'($urandom_range(0, 1));
            bus  = mk(pc, inst, 12'b1 << (11 - code), 3'b001 << s1c, 4'b0001 << s2c,
                      ren, wen, we, wa, srr, r1, r2);
            applyStimulus(bus);
            case (s1c)
                0:       a = r1;
                1:       a = pc;
                default: a = {27'd0, inst[10:6]};
            endcase
            case (s2c)
                0:       b = r2;
                1:       b = {{16{inst[15]}}, inst[15:0]};
                2:       b = 32'd8;
                default: b = {16'd0, inst[15:0]};
            endcase
            res     = refAlu(code, a, b);
            addrExp = a + b;
            checkOutput("rand_mem_bus", ex_to_mem_bus, {pc, ren, wen, srr, we, wa, res});
            checkOutput("rand_id_bus", ex_to_id_bus, {we, wa, res});
            checkOutput("rand_addr", data_sram_addr, addrExp);
            checkOutput("rand_sram", {data_sram_en, data_sram_wen, data_sram_wdata, is_load},
                        {ren, wen, r2, (ren && wen == 4'h0)});
        end

        for (int i = 0; i < 6; i++) begin
            r1 = $urandom;
            r2 = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom) >> $urandom_range(0, 28);
            doMult(1'($urandom_range(0, 1)), r1, r2);
            checkHiLo("rand_mult");
            doDiv(1'($urandom_range(0, 1)), r1, r2);
            checkHiLo("rand_div");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
